// File: rtl/judgement_scheduler.sv
// judgement_scheduler: gathers hit judgements from the arrow lanes, picks one
// at a time round-robin, hands it to the external score updater, waits out
// the updater latency and captures the authoritative score/streak results.
// Also runs the game-session state machine (idle, clear, run, drain, done).
module judgement_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int UPD_LATENCY = 2,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_start,
  input  logic                   game_end,
  input  logic [NUM_LANES-1:0]   lane_valid,
  input  logic [2*NUM_LANES-1:0] lane_code,
  output logic [NUM_LANES-1:0]   lane_ready,
  output logic [1:0]             upd_selector,
  output logic [CNT_W-1:0]       upd_score_in,
  output logic [CNT_W-1:0]       upd_streak_in,
  input  logic [CNT_W-1:0]       upd_score_out,
  input  logic [CNT_W-1:0]       upd_streak_out,
  output logic [CNT_W-1:0]       score,
  output logic [CNT_W-1:0]       streak,
  output logic [CNT_W-1:0]       max_streak,
  output logic                   busy,
  output logic                   done
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int WAIT_W = (UPD_LATENCY > 1) ? $clog2(UPD_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(UPD_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                      state_r;
  logic                        done_r;
  logic [NUM_LANES-1:0]        slot_full_r;
  logic [NUM_LANES-1:0][1:0]   slot_code_r;
  logic [LANE_W-1:0]           rr_ptr_r;
  logic                        in_flight_r;
  logic [WAIT_W-1:0]           wait_cnt_r;
  logic [CNT_W-1:0]            score_r;
  logic [CNT_W-1:0]            streak_r;
  logic [CNT_W-1:0]            max_streak_r;

  logic                        grant_s;
  logic [LANE_W-1:0]           grant_idx_s;
  logic [LANE_W-1:0]           cand_s;

  // Lane index (base + off) folded back into 0..NUM_LANES-1.
  function automatic logic [LANE_W-1:0] lane_wrap(input int base, input int off);
    int sum;
    sum = (base + off) % NUM_LANES;
    return sum[LANE_W-1:0];
  endfunction

  // A lane may hand over a judgement only while the session runs and its slot is free.
  always_comb begin
    lane_ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_ready[i] = (state_r == ST_RUN) && !slot_full_r[i];
    end
  end

  // Round-robin pick: first full slot at or after the pointer, only when the updater is idle.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && !in_flight_r) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        cand_s = lane_wrap(int'(rr_ptr_r), k);
        if (!grant_s && slot_full_r[cand_s]) begin
          grant_s     = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          grant_s = grant_s;
        end
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  assign upd_selector  = grant_s ? slot_code_r[grant_idx_s] : 2'b00;
  assign upd_score_in  = score_r;
  assign upd_streak_in = streak_r;
  assign score         = score_r;
  assign streak        = streak_r;
  assign max_streak    = max_streak_r;
  assign busy          = (|slot_full_r) || in_flight_r;
  assign done          = done_r;

  // Session state machine; done is raised on entry to DONE and dropped in CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (game_start) state_r <= ST_CLEAR;
          else            state_r <= ST_IDLE;
        end
        ST_CLEAR: begin
          done_r  <= 1'b0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (game_end) state_r <= ST_DRAIN;
          else          state_r <= ST_RUN;
        end
        ST_DRAIN: begin
          if (!(|slot_full_r) && !in_flight_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (game_start) state_r <= ST_CLEAR;
          else            state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // One-deep pending slot per lane: granted slots free up, code 00 is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_full_r <= '0;
      slot_code_r <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (grant_s && (int'(grant_idx_s) == i)) begin
          slot_full_r[i] <= 1'b0;
        end else if (lane_valid[i] && lane_ready[i] && (lane_code[2*i +: 2] != 2'b00)) begin
          slot_full_r[i] <= 1'b1;
          slot_code_r[i] <= lane_code[2*i +: 2];
        end else begin
          slot_full_r[i] <= slot_full_r[i];
        end
      end
    end
  end

  // Issue tracking, latency wait and capture of the updater results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight_r  <= 1'b0;
      wait_cnt_r   <= '0;
      rr_ptr_r     <= '0;
      score_r      <= '0;
      streak_r     <= '0;
      max_streak_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      score_r      <= '0;
      streak_r     <= '0;
      max_streak_r <= '0;
    end else if (grant_s) begin
      in_flight_r <= 1'b1;
      wait_cnt_r  <= '0;
      rr_ptr_r    <= lane_wrap(int'(grant_idx_s), 1);
    end else if (in_flight_r) begin
      if (wait_cnt_r == WAIT_LAST) begin
        in_flight_r <= 1'b0;
        score_r     <= upd_score_out;
        streak_r    <= upd_streak_out;
        if (upd_streak_out > max_streak_r) max_streak_r <= upd_streak_out;
        else                               max_streak_r <= max_streak_r;
      end else begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      in_flight_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_judgement_scheduler.sv
// Bench for judgement_scheduler: an external updater model plus a session-level
// reference model compared against the design on every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_judgement_scheduler;

  localparam int NL  = 4;
  localparam int LAT = 2;
  localparam int W   = 32;
  localparam int S_IDLE = 0, S_CLEAR = 1, S_RUN = 2, S_DRAIN = 3, S_DONE = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            game_start = 1'b0;
  logic            game_end = 1'b0;
  logic [NL-1:0]   lane_valid = '0;
  logic [2*NL-1:0] lane_code = '0;
  logic [NL-1:0]   lane_ready;
  logic [1:0]      upd_selector;
  logic [W-1:0]    upd_score_in, upd_streak_in;
  logic [W-1:0]    upd_score_out = '0, upd_streak_out = '0;
  logic [W-1:0]    score, streak, max_streak;
  logic            busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  judgement_scheduler #(.NUM_LANES(NL), .UPD_LATENCY(LAT), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .game_end(game_end),
    .lane_valid(lane_valid), .lane_code(lane_code), .lane_ready(lane_ready),
    .upd_selector(upd_selector), .upd_score_in(upd_score_in), .upd_streak_in(upd_streak_in),
    .upd_score_out(upd_score_out), .upd_streak_out(upd_streak_out),
    .score(score), .streak(streak), .max_streak(max_streak), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // External updater: ok +1, perfect +2, miss resets streak; +1 bonus once streak reaches 6.
  // Outputs carry the true result only in the capture cycle, garbage otherwise.
  bit         op_pend = 1'b0;
  int         op_cyc;
  logic [1:0] op_sel;
  logic [W-1:0] op_sc, op_st;
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      op_pend = 1'b0;
    end else begin
      if (upd_selector != 2'b00) begin
        op_pend = 1'b1; op_cyc = cyc; op_sel = upd_selector;
        op_sc = upd_score_in; op_st = upd_streak_in;
      end
      if (op_pend && cyc == op_cyc + LAT) begin
        logic [W-1:0] nst;
        nst = (op_sel == 2'b11) ? '0 : op_st + 1;
        upd_streak_out = nst;
        upd_score_out  = op_sc + ((op_sel == 2'b01) ? 1 : (op_sel == 2'b10) ? 2 : 0)
                         + ((op_sel != 2'b11 && nst >= 6) ? 1 : 0);
        op_pend = 1'b0;
      end else begin
        upd_score_out  = $urandom;
        upd_streak_out = $urandom;
      end
    end
  end

  // Reference model of the session.
  int         m_state;
  bit         m_pend[NL];
  logic [1:0] m_code[NL];
  int         m_ptr;
  int         m_cap;
  logic [W-1:0] m_score, m_streak, m_max;
  bit         m_done;
  int         m_issue_q[$];

  function automatic int model_pick();
    if (!(m_state == S_RUN || m_state == S_DRAIN) || m_cap >= 0) return -1;
    for (int k = 0; k < NL; k++) begin
      int l;
      l = (m_ptr + k) % NL;
      if (m_pend[l]) return l;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = S_IDLE; m_ptr = 0; m_cap = -1; m_done = 1'b0;
      m_score = '0; m_streak = '0; m_max = '0;
      for (int i = 0; i < NL; i++) begin m_pend[i] = 1'b0; m_code[i] = 2'b00; end
    end else begin
      int g;
      bit was_any;
      bit rdy[NL];
      g = model_pick();
      was_any = (m_cap >= 0);
      for (int i = 0; i < NL; i++) begin
        was_any = was_any | m_pend[i];
        rdy[i] = (m_state == S_RUN) && !m_pend[i];
      end
      if (m_cap >= 0 && cyc == m_cap) begin
        m_score = upd_score_out; m_streak = upd_streak_out;
        if (upd_streak_out > m_max) m_max = upd_streak_out;
        m_cap = -1;
      end
      if (g >= 0) begin
        m_pend[g] = 1'b0; m_cap = cyc + LAT; m_ptr = (g + 1) % NL;
        m_issue_q.push_back(g);
      end
      for (int i = 0; i < NL; i++)
        if (rdy[i] && lane_valid[i] && lane_code[2*i +: 2] != 2'b00) begin
          m_pend[i] = 1'b1; m_code[i] = lane_code[2*i +: 2];
        end
      case (m_state)
        S_IDLE:  if (game_start) m_state = S_CLEAR;
        S_CLEAR: begin m_score = '0; m_streak = '0; m_max = '0; m_done = 1'b0; m_state = S_RUN; end
        S_RUN:   if (game_end) m_state = S_DRAIN;
        S_DRAIN: if (!was_any) begin m_state = S_DONE; m_done = 1'b1; end
        S_DONE:  if (game_start) m_state = S_CLEAR;
        default: m_state = S_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      int g;
      logic [1:0] es;
      logic [NL-1:0] er;
      bit eb;
      g = model_pick();
      es = 2'b00;
      if (g >= 0) es = m_code[g];
      eb = (m_cap >= 0);
      for (int i = 0; i < NL; i++) begin
        er[i] = (m_state == S_RUN) && !m_pend[i];
        eb = eb | m_pend[i];
      end
      chk("upd_selector", upd_selector, es);
      chk("lane_ready", lane_ready, er);
      chk("score", score, m_score);
      chk("streak", streak, m_streak);
      chk("max_streak", max_streak, m_max);
      chk("upd_score_in", upd_score_in, m_score);
      chk("upd_streak_in", upd_streak_in, m_streak);
      chk("busy", busy, eb);
      chk("done", done, m_done);
    end
  end

  // Record issued selector codes and their cycles.
  logic [1:0] sel_q[$];
  int         selcyc_q[$];
  always @(negedge clk) begin
    if (!reset && upd_selector != 2'b00) begin
      sel_q.push_back(upd_selector);
      selcyc_q.push_back(cyc);
    end
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic pulse_start();
    game_start = 1'b1; tick(); game_start = 1'b0; tick();
  endtask

  task automatic hit(input int lane, input logic [1:0] code);
    lane_valid[lane] = 1'b1; lane_code[2*lane +: 2] = code;
    tick();
    lane_valid = '0; lane_code = '0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk(nm, done, 1'b1);
  endtask

  task automatic restart();
    game_end = 1'b1; tick(); game_end = 1'b0;
    wait_done("restart_done");
    pulse_start();
  endtask

  initial begin
    int six_exp[6];
    logic [W-1:0] saved;
    int n;
    six_exp = '{1, 2, 3, 4, 5, 7};
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_score", score, '0);
    chk("reset_ready", lane_ready, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // Three lanes at once: issues 0,1,3 spaced LAT+1 apart, pointer back at 0.
    pulse_start();
    chk("run_ready", lane_ready, 4'b1111);
    sel_q.delete(); selcyc_q.delete(); m_issue_q.delete();
    lane_valid = 4'b1011;
    lane_code  = {2'b01, 2'b00, 2'b10, 2'b01};
    tick();
    lane_valid = '0; lane_code = '0;
    wait_idle("tri_idle");
    chk("tri_count", sel_q.size(), 3);
    if (sel_q.size() == 3 && m_issue_q.size() == 3) begin
      chk("tri_lane0", m_issue_q[0], 0);
      chk("tri_lane1", m_issue_q[1], 1);
      chk("tri_lane2", m_issue_q[2], 3);
      chk("tri_code1", sel_q[1], 2'b10);
      chk("tri_gap0", selcyc_q[1] - selcyc_q[0], LAT + 1);
      chk("tri_gap1", selcyc_q[2] - selcyc_q[1], LAT + 1);
    end
    chk("tri_ptr", m_ptr, 0);
    chk("tri_score", score, 32'd4);

    // Single perfect hit on lane 2 in a fresh session.
    restart();
    sel_q.delete(); selcyc_q.delete();
    hit(2, 2'b10);
    wait_idle("t1_idle");
    chk("t1_sel", (sel_q.size() > 0) ? sel_q[0] : 2'b00, 2'b10);
    chk("t1_nsel", sel_q.size(), 1);
    chk("t1_score", score, 32'd2);
    chk("t1_streak", streak, 32'd1);
    chk("t1_max", max_streak, 32'd1);
    chk("t1_model_score", m_score, 32'd2);

    // Six ok hits on lane 0, then a miss, then a perfect hit.
    restart();
    for (int k = 0; k < 6; k++) begin
      hit(0, 2'b01);
      wait_idle("six_idle");
      chk("six_score", score, six_exp[k]);
    end
    chk("six_streak", streak, 32'd6);
    chk("six_max", max_streak, 32'd6);
    hit(1, 2'b11);
    wait_idle("miss_idle");
    chk("miss_score", score, 32'd7);
    chk("miss_streak", streak, 32'd0);
    chk("miss_max", max_streak, 32'd6);
    hit(1, 2'b10);
    wait_idle("perf_idle");
    chk("perf_score", score, 32'd9);
    chk("perf_model_score", m_score, 32'd9);

    // game_end with two slots pending: both complete before done.
    sel_q.delete(); selcyc_q.delete();
    lane_valid = 4'b0110;
    lane_code  = {2'b00, 2'b10, 2'b01, 2'b00};
    tick();
    lane_valid = '0; lane_code = '0;
    game_end = 1'b1; tick(); game_end = 1'b0;
    chk("drain_ready", lane_ready, '0);
    chk("drain_notdone", done, 1'b0);
    wait_done("drain_done");
    chk("drain_ops", sel_q.size(), 2);
    chk("drain_score", score, 32'd12);
    saved = score;
    lane_valid = 4'b1111; lane_code = 8'b0101_0101;
    repeat (3) tick();
    lane_valid = '0; lane_code = '0;
    chk("after_busy", busy, 1'b0);
    chk("after_score", score, saved);

    // Reset one cycle after an issue discards the in-flight op.
    pulse_start();
    hit(0, 2'b01);
    wait_idle("rst_pre_idle");
    hit(3, 2'b10);
    n = 0;
    while (upd_selector == 2'b00 && n < 10) begin tick(); n++; end
    chk("rst_issue_seen", n < 10, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_score", score, '0);
    chk("rst_streak", streak, '0);
    chk("rst_max", max_streak, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", upd_selector, 2'b00);
    chk("rst_ready", lane_ready, '0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_nocap", score, '0);

    // Randomized phase.
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      lane_valid = NL'($urandom & $urandom);
      lane_code  = (2*NL)'($urandom);
      game_start = ($urandom_range(0, 49) == 0);
      game_end   = ($urandom_range(0, 79) == 0);
      reset      = ($urandom_range(0, 399) == 0);
      tick();
    end
    lane_valid = '0; lane_code = '0; game_start = 1'b0; game_end = 1'b0; reset = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
